sp_ram_be: RTL and testbench

- Parametrised single-port synchronous RAM. Successor to the fixed 8x64 single-port RAM.
- Adds per-lane byte enables, a selectable read-during-write mode and a valid-qualified read response.
- Adds a hardware clear sequencer that writes INIT_VAL to every word after reset or on request.
- Sits as the local scratch memory behind the team's datapath blocks; one request port, one response port.

---
 rtl/sp_ram_be.sv | 124 ++++++++++++
 tb/tb_sp_ram_be.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_be.sv
// Parametrised single-port RAM with lane write enables, selectable read-during-write data and a clear sequencer.
// Optional SP_RAM_OUT_REG_EN adds one output register stage on q/q_valid.
module sp_ram_be #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                LANE_W   = 8,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data,
  input  logic [DATA_W/LANE_W-1:0]   be,
  output logic                       ready,
  output logic [DATA_W-1:0]          q,
  output logic                       q_valid,
  output logic                       clr_done
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int NUM_LANES = DATA_W / LANE_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [0:0]           r_state;
  logic [ADDR_W-1:0]    r_ptr;
  logic [DATA_W-1:0]    r_q;
  logic                 r_q_valid;

  logic                 w_clearing;
  logic                 w_accept;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic [DATA_W-1:0]    w_wr_data;
  logic [NUM_LANES-1:0] w_lane_we;
  logic [DATA_W-1:0]    w_rd_word;
  logic [DATA_W-1:0]    w_merged;

  assign w_clearing = (r_state == ST_CLEAR);
  // clr wins over a request presented in the same cycle
  assign w_accept   = (r_state == ST_IDLE) && req && !clr;
  assign w_wr_addr  = w_clearing ? r_ptr : addr;
  assign w_wr_data  = w_clearing ? INIT_VAL : data;
  assign w_lane_we  = w_clearing ? {NUM_LANES{1'b1}}
                                 : ((w_accept && we) ? be : {NUM_LANES{1'b0}});
  assign w_rd_word  = r_mem[addr];

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_merge
      assign w_merged[gi*LANE_W +: LANE_W] = be[gi] ? data[gi*LANE_W +: LANE_W]
                                                    : w_rd_word[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_wr_addr][i*LANE_W +: LANE_W] <= w_wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (clr) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (w_clearing) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      if (&r_ptr) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // r_q only moves together with a response strobe, so it holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      if (w_accept && !we) begin
        r_q       <= w_rd_word;
        r_q_valid <= 1'b1;
      end else if (w_accept && we && (RDW_MODE == 1)) begin
        r_q       <= w_merged;
        r_q_valid <= 1'b1;
      end
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign clr_done = w_clearing && (&r_ptr) && !clr;

`ifdef SP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] r_q_out;
  logic              r_q_valid_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_out       <= '0;
      r_q_valid_out <= 1'b0;
    end else begin
      r_q_out       <= r_q;
      r_q_valid_out <= r_q_valid;
    end
  end

  assign q       = r_q_out;
  assign q_valid = r_q_valid_out;
`else
  assign q       = r_q;
  assign q_valid = r_q_valid;
`endif

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench for sp_ram_be: an 8-bit read-first instance and a 32-bit write-first instance.
module tb_sp_ram_be;

`ifdef SP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        clr_a, req_a, we_a;
  logic [5:0]  addr_a;
  logic [7:0]  data_a;
  logic [0:0]  be_a;
  logic        ready_a, q_valid_a, clr_done_a;
  logic [7:0]  q_a;
  logic        clr_b, req_b, we_b;
  logic [5:0]  addr_b;
  logic [31:0] data_b;
  logic [3:0]  be_b;
  logic        ready_b, q_valid_b, clr_done_b;
  logic [31:0] q_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cap_q [16];
  logic        cap_v [16];
  int          ncap;

  sp_ram_be #(.DATA_W(8), .ADDR_W(6), .LANE_W(8), .RDW_MODE(0), .INIT_VAL(8'h00)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .req(req_a), .we(we_a), .addr(addr_a),
    .data(data_a), .be(be_a), .ready(ready_a), .q(q_a), .q_valid(q_valid_a),
    .clr_done(clr_done_a)
  );

  sp_ram_be #(.DATA_W(32), .ADDR_W(6), .LANE_W(8), .RDW_MODE(1), .INIT_VAL(32'hDEADBEEF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .req(req_b), .we(we_b), .addr(addr_b),
    .data(data_b), .be(be_b), .ready(ready_b), .q(q_b), .q_valid(q_valid_b),
    .clr_done(clr_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic record(input bit sel);
    cap_q[ncap] = sel ? q_b : {24'h0, q_a};
    cap_v[ncap] = sel ? q_valid_b : q_valid_a;
    ncap++;
  endtask

  task automatic issue(input bit sel, input bit w, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if (!sel) begin
      req_a = 1'b1; we_a = w; addr_a = a; data_a = d[7:0]; be_a = b[0:0];
    end else begin
      req_b = 1'b1; we_b = w; addr_b = a; data_b = d; be_b = b;
    end
    $display("%0t dut%0d %s addr=%0d data=%h be=%h", $time, sel, w ? "wr" : "rd", a, d, b);
    cyc();
    record(sel);
  endtask

  task automatic idle(input bit sel);
    req_a = 1'b0;
    req_b = 1'b0;
    cyc();
    record(sel);
  endtask

  task automatic clear_window(input string tag);
    for (int i = 0; i < 64; i++) begin
      chk({tag, "_ready"}, {31'h0, ready_a}, 32'h0);
      chk({tag, "_qv"}, {31'h0, q_valid_a}, 32'h0);
      chk({tag, "_done"}, {31'h0, clr_done_a}, (i == 63) ? 32'h1 : 32'h0);
      cyc();
    end
    chk({tag, "_ready_end"}, {31'h0, ready_a}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a = 0; req_a = 0; we_a = 0; addr_a = 0; data_a = 0; be_a = 0;
    clr_b = 0; req_b = 0; we_b = 0; addr_b = 0; data_b = 0; be_b = 0;
    repeat (3) cyc();
    chk("rst_ready", {31'h0, ready_a}, 32'h0);
    chk("rst_q", {24'h0, q_a}, 32'h0);
    chk("rst_qv", {31'h0, q_valid_a}, 32'h0);
    chk("rst_done", {31'h0, clr_done_a}, 32'h0);
    chk("rst_q_b", q_b, 32'h0);

    // Power-up clear: 64 cycles, done pulse on the last one
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("init_ready_b", {31'h0, ready_b}, 32'h0);
      chk("init_done_b", {31'h0, clr_done_b}, (i == 63) ? 32'h1 : 32'h0);
      chk("init_ready_a", {31'h0, ready_a}, 32'h0);
      chk("init_done_a", {31'h0, clr_done_a}, (i == 63) ? 32'h1 : 32'h0);
      cyc();
    end
    chk("init_ready_a_end", {31'h0, ready_a}, 32'h1);
    chk("init_ready_b_end", {31'h0, ready_b}, 32'h1);

    ncap = 0;
    issue(0, 0, 6'd0, 32'h0, 4'h1);
    issue(0, 0, 6'd31, 32'h0, 4'h1);
    issue(0, 0, 6'd63, 32'h0, 4'h1);
    idle(0); idle(0);
    for (int k = 0; k < 3; k++) begin
      chk("init_rd_q", cap_q[LAT-1+k], 32'h0);
      chk("init_rd_v", {31'h0, cap_v[LAT-1+k]}, 32'h1);
    end

    // Writes (read-first: no response) then back-to-back reads
    ncap = 0;
    issue(0, 1, 6'd0, 32'h01, 4'h1);
    issue(0, 1, 6'd1, 32'h02, 4'h1);
    issue(0, 1, 6'd2, 32'h03, 4'h1);
    issue(0, 0, 6'd0, 32'h0, 4'h1);
    issue(0, 0, 6'd1, 32'h0, 4'h1);
    issue(0, 0, 6'd2, 32'h0, 4'h1);
    idle(0); idle(0);
    for (int k = 0; k < 3; k++) begin
      chk("wr_no_resp", {31'h0, cap_v[LAT-1+k]}, 32'h0);
      chk("b2b_rd_q", cap_q[LAT+2+k], 32'(k + 1));
      chk("b2b_rd_v", {31'h0, cap_v[LAT+2+k]}, 32'h1);
    end
    chk("b2b_end_v", {31'h0, cap_v[LAT+5]}, 32'h0);
    chk("b2b_hold_q", cap_q[LAT+5], 32'h03);

    // Read-first: write gives no response and q holds, then read sees new data
    ncap = 0;
    issue(0, 1, 6'd3, 32'h55, 4'h1);
    idle(0); idle(0);
    issue(0, 0, 6'd3, 32'h0, 4'h1);
    idle(0); idle(0);
    chk("rdw0_wr_v", {31'h0, cap_v[LAT-1]}, 32'h0);
    chk("rdw0_wr_q", cap_q[LAT-1], 32'h03);
    chk("rdw0_rd_q", cap_q[LAT+2], 32'h55);
    chk("rdw0_rd_v", {31'h0, cap_v[LAT+2]}, 32'h1);

    // Write-first 32-bit instance with lane enables
    ncap = 0;
    issue(1, 0, 6'd7, 32'h0, 4'hF);
    issue(1, 1, 6'd5, 32'hAABBCCDD, 4'hF);
    issue(1, 1, 6'd5, 32'h11223344, 4'b0101);
    issue(1, 1, 6'd5, 32'hFFFFFFFF, 4'h0);
    issue(1, 0, 6'd5, 32'h0, 4'h0);
    idle(1); idle(1);
    chk("b_init_q", cap_q[LAT-1], 32'hDEADBEEF);
    chk("b_wf_full", cap_q[LAT], 32'hAABBCCDD);
    chk("b_wf_lanes", cap_q[LAT+1], 32'hAA22CC44);
    chk("b_wf_be0", cap_q[LAT+2], 32'hAA22CC44);
    chk("b_rd_lanes", cap_q[LAT+3], 32'hAA22CC44);
    for (int k = 0; k < 5; k++) chk("b_resp_v", {31'h0, cap_v[LAT-1+k]}, 32'h1);
    chk("b_end_v", {31'h0, cap_v[LAT+4]}, 32'h0);

    // Read of a word written on the previous cycle
    ncap = 0;
    issue(0, 1, 6'd1, 32'h02, 4'h1);
    issue(0, 0, 6'd1, 32'h0, 4'h1);
    idle(0); idle(0);
    chk("raw_q", cap_q[LAT], 32'h02);
    chk("raw_v", {31'h0, cap_v[LAT]}, 32'h1);

    // clr with a simultaneous write; requests during the clear are ignored
    clr_a = 1'b1; req_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; data_a = 8'h77; be_a = 1'b1;
    cyc();
    clr_a = 1'b0; we_a = 1'b0;
    clear_window("clr");
    req_a = 1'b0;
    for (int a = 0; a < 64 + LAT - 1; a++) begin
      if (a < 64) begin
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'(a);
      end else begin
        req_a = 1'b0;
      end
      cyc();
      if (a >= LAT - 1) begin
        chk("clr_rd_q", {24'h0, q_a}, 32'h0);
        chk("clr_rd_v", {31'h0, q_valid_a}, 32'h1);
      end
    end
    req_a = 1'b0;
    cyc();

    // Reset in the middle of a clear restarts the full sequence
    clr_a = 1'b1;
    cyc();
    clr_a = 1'b0;
    repeat (20) cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ready_a}, 32'h0);
    chk("midrst_qv", {31'h0, q_valid_a}, 32'h0);
    cyc();
    rst_n = 1'b1;
    clear_window("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
